// File: rtl/baccarat_pkg.sv
// rtl/baccarat_pkg.sv - shared states and thresholds for the baccarat hand sequencer
package baccarat_pkg;

    localparam int SCORE_W          = 4;
    localparam int NATURAL_MIN      = 8;
    localparam int PLAYER_STAND_MIN = 6;
    localparam int BANKER_STAND     = 7;

    typedef enum logic [3:0] {
        P1,
        D1,
        P2,
        D2,
        EVAL,
        P3,
        BANK,
        D3,
        DONE
    } state_t;

endpackage

// File: rtl/baccarat_sequencer_banker_draw_rule.sv
// rtl/baccarat_sequencer_banker_draw_rule.sv - banker third-card tableau after the player drew
import baccarat_pkg::*;

module banker_draw_rule (
    input  logic [SCORE_W-1:0] dscore,
    input  logic [SCORE_W-1:0] pcard3,
    output logic               draw
);

    always_comb begin
        draw = 1'b0;
        if (dscore < SCORE_W'(3)) begin
            draw = 1'b1;
        end else if (dscore < SCORE_W'(BANKER_STAND)) begin
            case (dscore)
                SCORE_W'(3): draw = (pcard3 != SCORE_W'(8));
                SCORE_W'(4): draw = (pcard3 >= SCORE_W'(2)) && (pcard3 <= SCORE_W'(7));
                SCORE_W'(5): draw = (pcard3 >= SCORE_W'(4)) && (pcard3 <= SCORE_W'(7));
                SCORE_W'(6): draw = (pcard3 >= SCORE_W'(6)) && (pcard3 <= SCORE_W'(7));
                default:     draw = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/baccarat_sequencer.sv
// rtl/baccarat_sequencer.sv - deal/draw/settle FSM driving datapath card loads and result lights
import baccarat_pkg::*;

module baccarat_sequencer (
    input  logic               slow_clock,
    input  logic               reset,
    input  logic               advance,
    input  logic [SCORE_W-1:0] pscore,
    input  logic [SCORE_W-1:0] dscore,
    input  logic [SCORE_W-1:0] pcard3,
    output logic               load_pcard1,
    output logic               load_pcard2,
    output logic               load_pcard3,
    output logic               load_dcard1,
    output logic               load_dcard2,
    output logic               load_dcard3,
    output logic               player_win_light,
    output logic               dealer_win_light
);

    state_t state;
    logic   banker_draw;
    logic   go;
    logic   natural;

    banker_draw_rule u_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (banker_draw)
    );

    // reset gates the strobes so the datapath sees nothing while the hand is abandoned
    assign go      = advance && !reset;
    assign natural = (pscore >= SCORE_W'(NATURAL_MIN)) || (dscore >= SCORE_W'(NATURAL_MIN));

    assign load_pcard1 = go && (state == P1);
    assign load_dcard1 = go && (state == D1);
    assign load_pcard2 = go && (state == P2);
    assign load_dcard2 = go && (state == D2);
    assign load_pcard3 = go && (state == P3);
    assign load_dcard3 = go && (state == D3);

    // every branch into DONE latches the lights; >= on both sides makes a tie light both
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            state            <= P1;
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end else if (advance) begin
            case (state)
                P1:   state <= D1;
                D1:   state <= P2;
                P2:   state <= D2;
                D2:   state <= EVAL;
                EVAL: begin
                    if (natural) begin
                        state            <= DONE;
                        player_win_light <= (pscore >= dscore);
                        dealer_win_light <= (dscore >= pscore);
                    end else if (pscore < SCORE_W'(PLAYER_STAND_MIN)) begin
                        state <= P3;
                    end else if (dscore < SCORE_W'(PLAYER_STAND_MIN)) begin
                        state <= D3;
                    end else begin
                        state            <= DONE;
                        player_win_light <= (pscore >= dscore);
                        dealer_win_light <= (dscore >= pscore);
                    end
                end
                P3:   state <= BANK;
                BANK: begin
                    if (banker_draw) begin
                        state <= D3;
                    end else begin
                        state            <= DONE;
                        player_win_light <= (pscore >= dscore);
                        dealer_win_light <= (dscore >= pscore);
                    end
                end
                D3: begin
                    state            <= DONE;
                    player_win_light <= (pscore >= dscore);
                    dealer_win_light <= (dscore >= pscore);
                end
                DONE:    state <= DONE;
                default: state <= P1;
            endcase
        end
    end

endmodule
